mem_access_ctrl: RTL and testbench

Sequencer for the MEM stage of the 5-stage pipeline. It watches the EX/MEM pipeline register outputs and runs each load or store as a req/ack transaction on a variable-latency data-memory port. While a transaction is outstanding it stalls the pipeline. It returns load data and records bus faults: misaligned address or ack timeout.

---
 rtl/mem_access_ctrl_if.sv | 19 +
 rtl/mem_access_ctrl.sv | 106 ++++++++++
 tb/tb_mem_access_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage sequencer and a variable-latency data memory.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns EX/MEM loads/stores into req/ack memory transactions,
// stalls the pipeline while one is outstanding, and records sticky bus faults.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              MEMm2reg,
  input  logic              MEMwmem,
  input  logic [31:0]       MEMaluResult,
  input  logic [31:0]       MEMdi,
  output logic              stall,
  output logic [31:0]       MEMdo,
  output logic              bus_fault,
  output logic [31:0]       fault_addr,
  mem_access_ctrl_if.master mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter value during the final permitted WAIT cycle.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_count;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_do;
  logic        r_fault;
  logic [31:0] r_faultAddr;

  logic w_memop;
  logic w_misaligned;
  logic w_timeout;

  assign w_memop      = MEMm2reg | MEMwmem;
  assign w_misaligned = (MEMaluResult[1:0] != 2'b00);
  assign w_timeout    = (r_count >= LP_LAST_WAIT);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_count     <= 8'd0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_do        <= 32'd0;
      r_fault     <= 1'b0;
      r_faultAddr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            if (w_misaligned) begin
              r_state <= S_DONE;
              r_fault <= 1'b1;
              if (!r_fault) r_faultAddr <= MEMaluResult;
              if (!MEMwmem) r_do <= 32'd0;
            end else begin
              r_state <= S_WAIT;
              r_req   <= 1'b1;
              r_we    <= MEMwmem;
              r_addr  <= MEMaluResult;
              r_wdata <= MEMdi;
              r_count <= 8'd0;
            end
          end
        end
        S_WAIT: begin
          // An ack on the last permitted cycle still completes cleanly.
          if (mem.mem_ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            if (!r_we) r_do <= mem.mem_rdata;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            if (!r_fault) r_faultAddr <= r_addr;
            if (!r_we) r_do <= 32'd0;
          end else if (r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall = clrn & (((r_state == S_IDLE) & w_memop) | (r_state == S_WAIT));

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign MEMdo         = r_do;
  assign bus_fault     = r_fault;
  assign fault_addr    = r_faultAddr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized checks of mem_access_ctrl against a transaction-level model
// of latency, returned data and sticky fault recording.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        clrn;
  logic        MEMm2reg;
  logic        MEMwmem;
  logic [31:0] MEMaluResult;
  logic [31:0] MEMdi;
  logic        stall;
  logic [31:0] MEMdo;
  logic        bus_fault;
  logic [31:0] fault_addr;

  mem_access_ctrl_if memBus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .MEMm2reg     (MEMm2reg),
    .MEMwmem      (MEMwmem),
    .MEMaluResult (MEMaluResult),
    .MEMdi        (MEMdi),
    .stall        (stall),
    .MEMdo        (MEMdo),
    .bus_fault    (bus_fault),
    .fault_addr   (fault_addr),
    .mem          (memBus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: what the architecturally visible outputs should hold.
  logic [31:0] expDo;
  logic        expFault;
  logic [31:0] expFaultAddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic modelReset();
    expDo        = 32'd0;
    expFault     = 1'b0;
    expFaultAddr = 32'd0;
  endtask

  task automatic resetDut();
    MEMm2reg       = 1'b1;
    MEMwmem        = 1'b0;
    MEMaluResult   = 32'h10;
    MEMdi          = 32'd0;
    memBus.mem_ack = 1'b0;
    clrn           = 1'b0;
    modelReset();
    #3;
    checkOutput("rst.stall", {31'd0, stall}, 32'd0);
    checkOutput("rst.req", {31'd0, memBus.mem_req}, 32'd0);
    checkOutput("rst.do", MEMdo, expDo);
    checkOutput("rst.fault", {31'd0, bus_fault}, {31'd0, expFault});
    MEMm2reg = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from IDLE to the edge ending DONE; ackAt is the WAIT cycle
  // (1-based) in which the memory answers, anything above TIMEOUT means never.
  task automatic applyStimulus(input string tag, input bit isLoad, input bit isStore,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int ackAt, input logic [31:0] rdata);
    bit          misaligned;
    bit          acked;
    int          expReq;
    int          expStall;
    int          stallCnt;
    int          reqCnt;
    int          cyc;
    bit          done;
    bit          fieldsOk;
    logic [31:0] doAtDone;
    logic        faultAtDone;
    logic [31:0] faultAddrAtDone;

    MEMm2reg         = isLoad;
    MEMwmem          = isStore;
    MEMaluResult     = addr;
    MEMdi            = wdata;
    memBus.mem_rdata = rdata;

    misaligned = (addr % 4) != 0;
    acked      = !misaligned && ackAt >= 1 && ackAt <= TIMEOUT;
    expReq     = misaligned ? 0 : (acked ? ackAt : TIMEOUT);
    expStall   = expReq + 1;
    if (misaligned || !acked) begin
      if (!expFault) expFaultAddr = addr;
      expFault = 1'b1;
      if (!isStore) expDo = 32'd0;
    end else if (!isStore) begin
      expDo = rdata;
    end

    stallCnt = 0; reqCnt = 0; cyc = 0; done = 0; fieldsOk = 1;
    doAtDone = 'x; faultAtDone = 'x; faultAddrAtDone = 'x;
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (memBus.mem_req) begin
        reqCnt++;
        if (memBus.mem_we !== isStore || memBus.mem_addr !== addr || memBus.mem_wdata !== wdata)
          fieldsOk = 0;
      end
      if (cyc > 0 && !stall && !memBus.mem_req) begin
        done            = 1;
        doAtDone        = MEMdo;
        faultAtDone     = bus_fault;
        faultAddrAtDone = fault_addr;
      end
      memBus.mem_ack = memBus.mem_req && (reqCnt == ackAt);
      @(posedge clk);
      #1;
      memBus.mem_ack = 1'b0;
      cyc++;
    end
    MEMm2reg = 1'b0;
    MEMwmem  = 1'b0;

    checkOutput({tag, ".doneSeen"}, {31'd0, done}, 32'd1);
    checkOutput({tag, ".stallCycles"}, stallCnt, expStall);
    checkOutput({tag, ".reqCycles"}, reqCnt, expReq);
    checkOutput({tag, ".reqFields"}, {31'd0, fieldsOk}, 32'd1);
    checkOutput({tag, ".MEMdo"}, doAtDone, expDo);
    checkOutput({tag, ".bus_fault"}, {31'd0, faultAtDone}, {31'd0, expFault});
    checkOutput({tag, ".fault_addr"}, faultAddrAtDone, expFaultAddr);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] addr;
    int          kind;
    int          idle;
    bit          sawThird;

    memBus.mem_rdata = 32'd0;
    resetDut();

    applyStimulus("load1", 1, 0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF);
    applyStimulus("store4", 0, 1, 32'h20, 32'h1234_5678, 4, 32'hFFFF_FFFF);
    applyStimulus("loadTimeout", 1, 0, 32'h40, 32'h0, TIMEOUT + 10, 32'hAAAA_5555);

    resetDut();
    applyStimulus("misStore", 0, 1, 32'h13, 32'hCAFE_0000, 1, 32'h0);
    applyStimulus("timeoutAfterMis", 1, 0, 32'h40, 32'h0, 0, 32'h0);

    resetDut();
    applyStimulus("ackOnLast", 1, 0, 32'h84, 32'h0, TIMEOUT, 32'h5A5A_1234);

    memBus.mem_ack = 1'b1;
    @(negedge clk);
    checkOutput("strayAck.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    memBus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("strayAck.req", {31'd0, memBus.mem_req}, 32'd0);
    checkOutput("strayAck.MEMdo", MEMdo, expDo);
    checkOutput("strayAck.stallAfter", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus("misStore2", 0, 1, 32'h101, 32'h0, 1, 32'h0);

    // Abandon a load during its third WAIT cycle.
    MEMm2reg     = 1'b1;
    MEMwmem      = 1'b0;
    MEMaluResult = 32'h80;
    sawThird     = 0;
    for (int c = 0; c < 10 && !sawThird; c++) begin
      @(negedge clk);
      if (memBus.mem_req && c == 3) sawThird = 1;
    end
    checkOutput("midReset.reached", {31'd0, sawThird}, 32'd1);
    clrn = 1'b0;
    modelReset();
    #1;
    checkOutput("midReset.req", {31'd0, memBus.mem_req}, 32'd0);
    checkOutput("midReset.addr", memBus.mem_addr, 32'd0);
    checkOutput("midReset.stall", {31'd0, stall}, 32'd0);
    checkOutput("midReset.MEMdo", MEMdo, expDo);
    checkOutput("midReset.fault", {31'd0, bus_fault}, {31'd0, expFault});
    checkOutput("midReset.faultAddr", fault_addr, expFaultAddr);
    MEMm2reg = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("afterReset", 1, 0, 32'h44, 32'h0, 1, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      if (i == 20) resetDut();
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        @(negedge clk);
        checkOutput("rnd.idleStall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
      end
      rnd  = $urandom;
      addr = rnd & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      kind = $urandom_range(0, 2);
      applyStimulus($sformatf("rnd%0d", i), kind != 1, kind != 0, addr, $urandom,
                    $urandom_range(1, TIMEOUT + 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
